// File: rtl/acc_pkg.sv
// Shared definitions for the multi-channel fixed-point accumulator:
// default geometry, sum limits for the default width, channel index type
// and the index-width helper.
package acc_pkg;

    localparam int ACC_WIDTH    = 26;
    localparam int ACC_FRAC     = 13;
    localparam int ACC_CHANNELS = 4;

    // Index width that never collapses to zero, so a single-channel build
    // still has a one-bit channel port.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

    // Two's complement limits of a default-width sum.
    localparam logic [ACC_WIDTH-1:0] SUM_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SUM_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef logic [clog2_min1(ACC_CHANNELS)-1:0] chan_t;

endpackage

// File: rtl/fxp_sat_add.sv
// Combinational WIDTH-bit signed adder with an overflow indication.
// Build option: define ACC_SATURATE_EN to clamp overflowing results to the
// most positive / most negative value; otherwise results wrap.
module fxp_sat_add
    import acc_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    // One guard bit: the top two bits disagree exactly when the true
    // result does not fit in WIDTH bits.
    logic [WIDTH:0] wide;

    assign wide = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    assign ovf  = wide[WIDTH] ^ wide[WIDTH-1];

`ifdef ACC_SATURATE_EN
    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Clamp toward the sign of the true result (the guard bit) on overflow.
    always_comb begin
        sum = wide[WIDTH-1:0];
        if (ovf) begin
            sum = wide[WIDTH] ? NEG_MIN : POS_MAX;
        end
    end
`else
    assign sum = wide[WIDTH-1:0];
`endif

endmodule

// File: rtl/multichan_fxp_accumulator.sv
// CHANNELS independent signed fixed-point running sums with a one-deep
// back-pressured result register, per-channel clear and sticky overflow.
// Build option: ACC_SATURATE_EN selects clamping instead of wrapping
// (implemented inside fxp_sat_add).
module multichan_fxp_accumulator
    import acc_pkg::*;
#(
    parameter int WIDTH    = ACC_WIDTH,
    parameter int FRAC     = ACC_FRAC,
    parameter int CHANNELS = ACC_CHANNELS,
    localparam int CW      = clog2_min1(CHANNELS)
) (
    input  logic                clk,
    input  logic                GlobalReset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CW-1:0]       in_chan,
    input  logic [WIDTH-1:0]    in_incr,
    input  logic                clr,
    input  logic [CW-1:0]       clr_chan,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CW-1:0]       out_chan,
    output logic [WIDTH-1:0]    out_sum,
    output logic [CHANNELS-1:0] ovf
);

    // The binary point position does not affect the arithmetic; it only
    // has to lie inside the word.
    if (FRAC < 0 || FRAC >= WIDTH) begin : g_bad_frac
        $error("FRAC must lie in [0, WIDTH)");
    end

    logic [WIDTH-1:0]    sum_reg [CHANNELS];
    logic [CHANNELS-1:0] ovf_reg;
    logic                out_valid_reg;
    logic [CW-1:0]       out_chan_reg;
    logic [WIDTH-1:0]    out_sum_reg;

    logic [CHANNELS-1:0] in_hit;
    logic [CHANNELS-1:0] clr_hit;
    logic                chan_ok;
    logic                accept;
    logic                clr_same;
    logic [WIDTH-1:0]    cur_sum;
    logic [WIDTH-1:0]    base_sum;
    logic [WIDTH-1:0]    add_sum;
    logic                add_ovf;

    // One-hot channel decode; an out-of-range index simply hits nothing,
    // which makes the increment or clear a no-op.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_decode
        assign in_hit[gi]  = (in_chan  == CW'(gi));
        assign clr_hit[gi] = (clr_chan == CW'(gi));
    end

    assign in_ready = !out_valid_reg | out_ready;
    assign accept   = in_valid & in_ready;
    assign chan_ok  = |in_hit;
    // Clear on the channel being added to: the add starts from zero.
    assign clr_same = clr & (|(clr_hit & in_hit));

    // Read the addressed running sum (zero when the index is out of range).
    always_comb begin
        cur_sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (in_hit[i]) begin
                cur_sum = sum_reg[i];
            end
        end
    end

    assign base_sum = clr_same ? '0 : cur_sum;

    fxp_sat_add #(
        .WIDTH (WIDTH)
    ) u_add (
        .a   (base_sum),
        .b   (in_incr),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // Per-channel sums and sticky overflow: the add wins over a plain clear,
    // and a same-cycle clear only discards the old flag before the add's own.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sum_reg[i] <= '0;
            end
            ovf_reg <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (accept && in_hit[i]) begin
                    sum_reg[i] <= add_sum;
                    ovf_reg[i] <= ((clr && clr_hit[i]) ? 1'b0 : ovf_reg[i]) | add_ovf;
                end else if (clr && clr_hit[i]) begin
                    sum_reg[i] <= '0;
                    ovf_reg[i] <= 1'b0;
                end
            end
        end
    end

    // Result register: load on an in-range accept, drop on a pop, else hold.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            out_valid_reg <= 1'b0;
            out_chan_reg  <= '0;
            out_sum_reg   <= '0;
        end else if (accept && chan_ok) begin
            out_valid_reg <= 1'b1;
            out_chan_reg  <= in_chan;
            out_sum_reg   <= add_sum;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_chan  = out_chan_reg;
    assign out_sum   = out_sum_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_multichan_fxp_accumulator.sv
// Bench for multichan_fxp_accumulator (default geometry: 26 bits, 4 channels).
// A behavioural model of the running sums is checked on every falling edge;
// directed steps additionally pin hand-computed literal results.
module tb_multichan_fxp_accumulator;
    import acc_pkg::*;

    localparam int W  = 26;
    localparam int CH = 4;
    localparam int CW = 2;
    localparam longint MAXV = (64'sd1 <<< (W-1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (W-1));

    logic          clk = 1'b0;
    logic          GlobalReset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_chan = '0;
    logic [W-1:0]  in_incr = '0;
    logic          clr = 1'b0;
    logic [CW-1:0] clr_chan = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] out_chan;
    logic [W-1:0]  out_sum;
    logic [CH-1:0] ovf;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    multichan_fxp_accumulator dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_chan     (in_chan),
        .in_incr     (in_incr),
        .clr         (clr),
        .clr_chan    (clr_chan),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_chan    (out_chan),
        .out_sum     (out_sum),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    function automatic longint sx(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint        m_sum [CH];
    logic [CH-1:0] m_ovf;
    logic          m_valid;
    logic [CW-1:0] m_chan;
    logic [W-1:0]  m_out;
    longint        mb, mt, mr;
    logic          mo;
    logic          m_acc;

    always @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            for (int i = 0; i < CH; i++) m_sum[i] <= 0;
            m_ovf   <= '0;
            m_valid <= 1'b0;
            m_chan  <= '0;
            m_out   <= '0;
        end else begin
            m_acc = in_valid && (!m_valid || out_ready);
            if (m_acc) begin
                mb = (clr && clr_chan == in_chan) ? 0 : m_sum[in_chan];
                mt = mb + sx(in_incr);
                mo = (mt > MAXV) || (mt < MINV);
`ifdef ACC_SATURATE_EN
                mr = (mt > MAXV) ? MAXV : ((mt < MINV) ? MINV : mt);
`else
                mr = sx(mt[W-1:0]);
`endif
                m_sum[in_chan] <= mr;
                m_ovf[in_chan] <= mo | ((clr && clr_chan == in_chan) ? 1'b0 : m_ovf[in_chan]);
                m_valid <= 1'b1;
                m_chan  <= in_chan;
                m_out   <= mr[W-1:0];
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
            if (clr && !(m_acc && clr_chan == in_chan)) begin
                m_sum[clr_chan] <= 0;
                m_ovf[clr_chan] <= 1'b0;
            end
        end
    end

    // Compare process: every falling edge once checking is enabled.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_out_valid", 64'(out_valid), 64'(m_valid));
            chk("model_in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
            chk("model_ovf", 64'(ovf), 64'(m_ovf));
            if (m_valid) begin
                chk("model_out_chan", 64'(out_chan), 64'(m_chan));
                chk("model_out_sum", 64'(out_sum), 64'(m_out));
            end
        end
    end

    // One clock cycle of stimulus, then a log line of the visible result.
    task automatic step(input logic v, input int ch, input logic [W-1:0] incr,
                        input logic c, input int cch, input logic rdy);
        in_valid  = v;
        in_chan   = CW'(ch);
        in_incr   = incr;
        clr       = c;
        clr_chan  = CW'(cch);
        out_ready = rdy;
        @(posedge clk);
        #1;
        $display("TXN t=%0t v=%0d ch=%0d incr=0x%07h clr=%0d/%0d rdy=%0d -> out_valid=%0d ch=%0d sum=0x%07h ovf=%b",
                 $time, v, ch, incr, c, cch, rdy, out_valid, out_chan, out_sum, ovf);
    endtask

    logic [W-1:0] exp_wrap_pos;
    logic [W-1:0] exp_wrap_neg;

    initial begin
`ifdef ACC_SATURATE_EN
        exp_wrap_pos = SUM_MAX;      // 0x1FFFFFF
        exp_wrap_neg = SUM_MIN;      // 0x2000000
`else
        exp_wrap_pos = 26'h2000000;
        exp_wrap_neg = 26'h1FFFFFD;  // -3 + -2^25 wrapped
`endif
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        GlobalReset = 1'b0;
        chk_en = 1'b1;

        // Same channel back-to-back
        step(1, 0, 26'h0001000, 0, 0, 1);
        chk("ch0_first", 64'(out_sum), 64'h1000);
        step(1, 0, 26'h0001000, 0, 0, 1);
        chk("ch0_second", 64'(out_sum), 64'h2000);
        step(1, 0, 26'h0001000, 0, 0, 1);
        chk("ch0_third", 64'(out_sum), 64'h3000);
        chk("ch0_chan", 64'(out_chan), 64'd0);

        // Interleaved channels
        step(1, 1, 26'd5, 0, 0, 1);
        chk("ch1_a", 64'(out_sum), 64'd5);
        step(1, 2, 26'h3FFFFFD, 0, 0, 1);
        chk("ch2_neg", 64'(out_sum), 64'h3FFFFFD);
        step(1, 1, 26'd5, 0, 0, 1);
        chk("ch1_b", 64'(out_sum), 64'd10);
        chk("ch1_b_chan", 64'(out_chan), 64'd1);

        // Back-pressure: held result, no accept for 10 cycles
        for (int k = 0; k < 10; k++) begin
            step(1, 0, 26'd1, 0, 0, 0);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_sum", 64'(out_sum), 64'd10);
            chk("hold_valid", 64'(out_valid), 64'd1);
        end
        step(1, 0, 26'd1, 0, 0, 1);
        chk("release_sum", 64'(out_sum), 64'h3001);
        chk("release_chan", 64'(out_chan), 64'd0);

        // Positive overflow on ch3
        step(1, 3, 26'h1FFFFFF, 0, 0, 1);
        chk("ch3_max", 64'(out_sum), 64'h1FFFFFF);
        step(1, 3, 26'd1, 0, 0, 1);
        chk("ch3_ovf_sum", 64'(out_sum), 64'(exp_wrap_pos));
        chk("ch3_ovf_flag", 64'(ovf), 64'b1000);

        // Clear plus accept on the same channel
        step(1, 3, 26'd7, 1, 3, 1);
        chk("clr_add_sum", 64'(out_sum), 64'd7);
        chk("clr_add_ovf", 64'(ovf), 64'd0);

        // Standalone clear: no output, then restart from zero
        step(0, 0, 26'd0, 1, 1, 1);
        chk("clr_only_valid", 64'(out_valid), 64'd0);
        step(1, 1, 26'd1, 0, 0, 1);
        chk("ch1_after_clr", 64'(out_sum), 64'd1);

        // Negative overflow on ch2 (-3 + most negative)
        step(1, 2, 26'h2000000, 0, 0, 1);
        chk("ch2_ovf_sum", 64'(out_sum), 64'(exp_wrap_neg));
        chk("ch2_ovf_flag", 64'(ovf), 64'b0100);

        // Mixed traffic checked by the model
        for (int k = 0; k < 40; k++) begin
            step(($urandom_range(0, 3) != 0), int'($urandom_range(0, CH-1)),
                 W'($urandom), ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, CH-1)), ($urandom_range(0, 2) != 0));
        end

        // Asynchronous reset with a result pending
        step(1, 0, 26'd5, 0, 0, 0);
        #2;
        GlobalReset = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_sum", 64'(out_sum), 64'd0);
        chk("arst_chan", 64'(out_chan), 64'd0);
        chk("arst_ovf", 64'(ovf), 64'd0);
        @(posedge clk);
        #1;
        GlobalReset = 1'b0;
        step(1, 0, 26'd2, 0, 0, 1);
        chk("post_rst_sum", 64'(out_sum), 64'd2);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        step(0, 0, 26'd0, 0, 0, 1);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
